mem_port_arbiter: RTL

- Round-robin arbiter and sequencer for the CPU's single shared memory port, used by three requesters: req0 = instruction fetch, req1 = load/store, req2 = debug/DMA.
- Drives the 2-bit select of the 3:1 port mux (00 = value1/req0, 01 = value2/req1, 10 = value3/req2) and the port's valid strobe.
- Holds a grant until the memory acknowledges, then returns a per-requester done pulse.
- Aborts with an error if the memory stalls past a timeout.

---
 rtl/mem_port_arbiter_if.sv | 22 ++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Shared memory port bundle between the requester side and the port arbiter.
// master = arbiter view, slave = requester/memory view.
interface mem_port_arbiter_if;
  logic [2:0] req;
  logic       mem_ready;
  logic [2:0] grant;
  logic [1:0] sel;
  logic       mem_valid;
  logic [2:0] done;
  logic       err;
  logic       busy;

  modport master (
    input  req, mem_ready,
    output grant, sel, mem_valid, done, err, busy
  );

  modport slave (
    output req, mem_ready,
    input  grant, sel, mem_valid, done, err, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer for the single shared memory port (3 requesters).
// Holds a grant until mem_ready, pulses done (and err on timeout) to the winner.
module mem_port_arbiter #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_port_arbiter_if.master     bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 32'd0) ? 32'd0 : TIMEOUT - 32'd1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [2:0]       done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic [1:0]       win;
  logic             timeout_hit;
  logic             finish;

  // First requester at or after ptr, wrapping mod 3
  always_comb begin
    win = 2'd0;
    case (ptr_q)
      2'd1:    win = bus.req[1] ? 2'd1 : (bus.req[2] ? 2'd2 : 2'd0);
      2'd2:    win = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
      default: win = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
    endcase
  end

  // mem_ready takes precedence over a coincident timeout
  assign timeout_hit = (TIMEOUT != 32'd0) && (state_q == S_BUSY) &&
                       !bus.mem_ready && (cnt_q == CNT_LAST);
  assign finish      = (state_q == S_BUSY) && (bus.mem_ready || timeout_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      grant_q <= 3'b000;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
      done_q  <= 3'b000;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.req != 3'b000) state_d = S_BUSY;
      S_BUSY:  if (finish)            state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // sel holds its last granted value while idle to keep the mux stable
  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = 3'b000;
    sel_d   = sel_q;
    valid_d = 1'b0;
    done_d  = 3'b000;
    err_d   = 1'b0;
    busy_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req != 3'b000) begin
          grant_d = 3'b001 << win;
          sel_d   = win;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        if (finish) begin
          done_d = grant_q;
          err_d  = timeout_hit;
          ptr_d  = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
        end else begin
          grant_d = grant_q;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.mem_valid = valid_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;

endmodule
